// File: rtl/risc_run_ctrl.sv
// Run-control sequencer for VeriRISC: instruction phase, core enable, HLT/step/stop handling, debug bus arbitration.
// Optional breakpoint comparator enabled by defining BREAKPOINT_EN.
module risc_run_ctrl #(
    parameter int AWIDTH = 5,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic [AWIDTH-1:0] pc_addr,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_stop,
    input  logic              dbg_req,
    input  logic [AWIDTH-1:0] bp_addr,
    input  logic              bp_valid,
    output logic [2:0]        phase,
    output logic              cpu_en,
    output logic              dbg_gnt,
    output logic              running,
    output logic              halted,
    output logic              bp_hit,
    output logic [CWIDTH-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED,
        S_DBG
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        phase_reg, phase_next;
    logic [CWIDTH-1:0] cnt_reg, cnt_next;
    logic              bp_hit_reg, bp_hit_next;
    logic              pend_reg, pend_next;
    logic              skip_reg, skip_next;
    logic              ret_halted_reg, ret_halted_next;
    logic              bp_match;

`ifdef BREAKPOINT_EN
    assign bp_match = bp_valid && (pc_addr == bp_addr) && !skip_reg;
`else
    assign bp_match = 1'b0;
    logic bp_unused;
    assign bp_unused = &{1'b0, bp_valid, bp_addr, pc_addr, skip_reg};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            phase_reg      <= 3'd0;
            cnt_reg        <= '0;
            bp_hit_reg     <= 1'b0;
            pend_reg       <= 1'b0;
            skip_reg       <= 1'b0;
            ret_halted_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            cnt_reg        <= cnt_next;
            bp_hit_reg     <= bp_hit_next;
            pend_reg       <= pend_next;
            skip_reg       <= skip_next;
            ret_halted_reg <= ret_halted_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        cnt_next        = cnt_reg;
        bp_hit_next     = bp_hit_reg;
        pend_next       = pend_reg;
        skip_next       = skip_reg;
        ret_halted_next = ret_halted_reg;
        case (state_reg)
            S_IDLE, S_HALTED: begin
                // cmd_stop has no effect here but still outranks step/run
                if (cmd_step && !cmd_stop) begin
                    state_next  = S_STEP;
                    phase_next  = 3'd0;
                    bp_hit_next = 1'b0;
                    skip_next   = 1'b1;
                    pend_next   = 1'b0;
                end else if (cmd_run && !cmd_stop) begin
                    state_next  = S_RUN;
                    phase_next  = 3'd0;
                    bp_hit_next = 1'b0;
                    skip_next   = 1'b1;
                    pend_next   = 1'b0;
                end else if (dbg_req) begin
                    state_next      = S_DBG;
                    ret_halted_next = (state_reg == S_HALTED);
                end
            end
            S_RUN, S_STEP: begin
                if (phase_reg == 3'd0) begin
                    skip_next = 1'b0;
                end
                if ((phase_reg == 3'd0) && bp_match) begin
                    // Stop before executing: phase stays 0, nothing retires
                    state_next  = S_IDLE;
                    phase_next  = 3'd0;
                    bp_hit_next = 1'b1;
                    pend_next   = 1'b0;
                end else begin
                    phase_next = phase_reg + 3'd1;
                    if ((state_reg == S_RUN) && cmd_stop) begin
                        pend_next = 1'b1;
                    end
                    if ((phase_reg == 3'd4) && halt) begin
                        state_next = S_HALTED;
                        phase_next = 3'd0;
                        cnt_next   = cnt_reg + 1'b1;
                        pend_next  = 1'b0;
                    end else if (phase_reg == 3'd7) begin
                        cnt_next = cnt_reg + 1'b1;
                        if ((state_reg == S_STEP) || pend_reg || cmd_stop) begin
                            state_next = S_IDLE;
                            pend_next  = 1'b0;
                        end
                    end
                end
            end
            S_DBG: begin
                if (!dbg_req) begin
                    state_next = ret_halted_reg ? S_HALTED : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                phase_next = 3'd0;
            end
        endcase
    end

    assign phase     = phase_reg;
    assign cpu_en    = (state_reg == S_RUN) || (state_reg == S_STEP);
    assign running   = cpu_en;
    assign halted    = (state_reg == S_HALTED);
    assign dbg_gnt   = (state_reg == S_DBG);
    assign bp_hit    = bp_hit_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Directed bench for risc_run_ctrl with hand-computed expectations; counter width reduced to exercise wrap.
module tb_risc_run_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt, cmd_run, cmd_step, cmd_stop, dbg_req, bp_valid;
    logic [AW-1:0] pc_addr, bp_addr;
    logic [2:0]    phase;
    logic          cpu_en, dbg_gnt, running, halted, bp_hit;
    logic [CW-1:0] instr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    risc_run_ctrl #(.AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .halt(halt), .pc_addr(pc_addr),
        .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
        .dbg_req(dbg_req), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .phase(phase), .cpu_en(cpu_en), .dbg_gnt(dbg_gnt),
        .running(running), .halted(halted), .bp_hit(bp_hit),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; halt = 0; cmd_run = 0; cmd_step = 0; cmd_stop = 0;
        dbg_req = 0; bp_valid = 0; pc_addr = '0; bp_addr = '0;
        tick(2);
        rst = 1'b0;
        tick();
        check("rst_phase", phase, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_halted", halted, 0);
        check("rst_gnt", dbg_gnt, 0);
        check("rst_bp_hit", bp_hit, 0);

        // Free run: phase 0..7 repeating, three instructions in 24 clocks
        cmd_run = 1; tick(); cmd_run = 0;
        for (int i = 0; i < 24; i++) begin
            check($sformatf("run_phase%0d", i), phase, i % 8);
            tick();
        end
        check("run_cnt3", instr_cnt, 3);
        check("run_cpu_en", cpu_en, 1);

        // Stop at phase 2 finishes the instruction
        tick(2);
        cmd_stop = 1; tick(); cmd_stop = 0;
        tick(4);
        check("stop_p7_running", running, 1);
        check("stop_p7_phase", phase, 7);
        tick();
        check("stop_idle", running, 0);
        check("stop_phase0", phase, 0);
        check("stop_cnt4", instr_cnt, 4);

        // Single step: exactly 8 enabled cycles
        cmd_step = 1; tick(); cmd_step = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("step_en%0d", i), cpu_en, 1);
            tick();
        end
        check("step_done_en", cpu_en, 0);
        check("step_done_phase", phase, 0);
        check("step_cnt5", instr_cnt, 5);

        // stop+run together in IDLE: stop wins, stays IDLE
        cmd_stop = 1; cmd_run = 1; tick(); cmd_stop = 0; cmd_run = 0;
        check("stoprun_idle", running, 0);

        // HLT at phase 4
        cmd_run = 1; tick(); cmd_run = 0;
        tick(4);
        check("hlt_p4", phase, 4);
        halt = 1; tick(); halt = 0;
        check("hlt_halted", halted, 1);
        check("hlt_phase0", phase, 0);
        check("hlt_cpu_en", cpu_en, 0);
        check("hlt_cnt6", instr_cnt, 6);
        cmd_stop = 1; tick(); cmd_stop = 0;
        check("hlt_stop_ignored", halted, 1);

        // Debug grant from HALTED, commands ignored in DBG, return to HALTED
        dbg_req = 1; tick();
        check("dbg_gnt", dbg_gnt, 1);
        check("dbg_not_halted", halted, 0);
        cmd_run = 1; tick(); cmd_run = 0;
        check("dbg_run_ignored", dbg_gnt, 1);
        check("dbg_run_no_en", cpu_en, 0);
        dbg_req = 0; tick();
        check("dbg_back_halted", halted, 1);
        check("dbg_released", dbg_gnt, 0);

        // Resume after HLT; halt at phase 6 ignored
        cmd_run = 1; tick(); cmd_run = 0;
        check("resume_running", running, 1);
        check("resume_phase0", phase, 0);
        tick(6);
        halt = 1; tick(); halt = 0;
        check("halt_p6_ignored", halted, 0);
        check("halt_p6_phase7", phase, 7);
        tick();
        check("resume_cnt7", instr_cnt, 7);

        // dbg_req in RUN waits for the stop at the boundary
        dbg_req = 1; tick(3);
        check("run_dbg_wait", dbg_gnt, 0);
        cmd_stop = 1; tick(); cmd_stop = 0;
        tick(3);
        check("run_dbg_wait_p7", dbg_gnt, 0);
        tick();
        check("run_dbg_idle", running, 0);
        check("run_dbg_cnt8", instr_cnt, 8);
        tick();
        check("run_dbg_granted", dbg_gnt, 1);
        dbg_req = 0; tick();
        check("dbg_back_idle_gnt", dbg_gnt, 0);
        check("dbg_back_idle_halted", halted, 0);

        // Counter wrap at 2^CW
        cmd_run = 1; tick(); cmd_run = 0;
        tick(64);
        check("cnt_wrap", instr_cnt, 0);
        tick(13);
        check("pre_rst_cnt", instr_cnt, 1);
        check("pre_rst_phase", phase, 5);

        // Asynchronous reset mid-instruction
        rst = 1; #1;
        check("arst_phase", phase, 0);
        check("arst_running", running, 0);
        check("arst_cnt", instr_cnt, 0);
        tick(); rst = 0; tick();

        // Breakpoint at PC 4
        bp_addr = 5'h04; bp_valid = 1; pc_addr = 5'h00;
        cmd_run = 1; tick(); cmd_run = 0;
        for (int k = 0; k < 4; k++) begin
            tick(8);
            pc_addr = AW'(k + 1);
        end
        check("bp_pre_cnt4", instr_cnt, 4);
        tick();
`ifdef BREAKPOINT_EN
        check("bp_stopped", running, 0);
        check("bp_hit_set", bp_hit, 1);
        check("bp_phase0", phase, 0);
        check("bp_cnt4", instr_cnt, 4);
        cmd_run = 1; tick(); cmd_run = 0;
        check("bp_resume_clear", bp_hit, 0);
        tick();
        check("bp_resume_exec", phase, 1);
`else
        check("nobp_running", running, 1);
        check("nobp_hit", bp_hit, 0);
        check("nobp_phase1", phase, 1);
`endif
        tick(7);
        check("bp_after_cnt5", instr_cnt, 5);
        check("bp_after_running", running, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/risc_run_ctrl.md
Name: risc_run_ctrl

Overview:
Run-control sequencer for the VeriRISC core. It generates the 3-bit instruction phase consumed by the instruction decoder and gates the core's register enables. It handles run, single-step and stop commands and the HLT instruction. It also arbitrates the single memory/data bus between the core and an external debug/loader port.

Parameters:
AWIDTH, 5, width of program counter / memory address
CWIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
halt  input  1  halt decode from instruction decoder (meaningful in phase 4 only)
pc_addr  input  AWIDTH  current program counter value
cmd_run  input  1  single-cycle pulse: free-run
cmd_step  input  1  single-cycle pulse: execute exactly one instruction
cmd_stop  input  1  single-cycle pulse: stop at next instruction boundary
dbg_req  input  1  debug port requests memory bus (level)
bp_addr  input  AWIDTH  breakpoint address (used only with BREAKPOINT_EN)
bp_valid  input  1  breakpoint armed (used only with BREAKPOINT_EN)
phase  output  3  instruction phase to decoder
cpu_en  output  1  enable for PC/IR/ACC/memory-write strobes
dbg_gnt  output  1  memory bus granted to debug port
running  output  1  state is RUN or STEP
halted  output  1  state is HALTED
bp_hit  output  1  sticky: stopped on breakpoint
instr_cnt  output  CWIDTH  retired-instruction count

Behaviour:
- Reset (async, any time, including mid-instruction):
  - state=IDLE; phase=0; instr_cnt=0; bp_hit=0; pending-stop=0; resume-skip=0.
  - All other outputs 0.
- States: IDLE (stopped), RUN, STEP, HALTED (HLT executed), DBG (bus granted).
- Combinational outputs:
  - cpu_en=1 iff state is RUN or STEP.
  - running mirrors cpu_en.
  - halted=1 iff state is HALTED.
  - dbg_gnt=1 iff state is DBG.
- Phase counting:
  - While cpu_en=1, phase increments by one per clk and wraps 7->0.
  - Outside RUN/STEP, phase holds 0.
  - Phase always resumes at 0 (instruction boundary).
- Retiring an instruction: the edge leaving phase 7 with cpu_en=1 retires it; instr_cnt increments by 1 and wraps at 2^CWIDTH.
- Command priority when several are sampled in the same cycle: cmd_stop > cmd_step > cmd_run. Commands sampled while in DBG are ignored.
- IDLE:
  - cmd_run -> RUN.
  - cmd_step -> STEP.
  - Else dbg_req -> DBG.
  - Entering RUN/STEP clears bp_hit and sets resume-skip.
- RUN:
  - cmd_stop sets pending-stop.
  - At the phase-7 edge: if pending-stop (or cmd_stop in that same cycle), go to IDLE and clear pending-stop; else stay in RUN.
  - cmd_run/cmd_step are ignored.
- STEP: at the phase-7 edge -> IDLE. cmd_stop is redundant and has no effect.
- HLT instruction:
  - When halt=1 with phase=4 and cpu_en=1, the phase-4 cycle completes (decoder's inc_pc takes effect). The next state is HALTED with phase=0; the instruction counts as retired.
  - halt at any other phase is ignored.
- HALTED:
  - cmd_run -> RUN; cmd_step -> STEP; resume fetches the instruction after HLT.
  - Else dbg_req -> DBG.
  - cmd_stop is ignored.
- DBG:
  - Entered only from IDLE or HALTED; the originating state is remembered.
  - dbg_gnt is held while dbg_req=1.
  - When dbg_req falls, return to the originating state next cycle (1-cycle latency).
  - dbg_req is never granted while cpu_en=1; the requester waits.
- cmd_stop while IDLE/HALTED: no effect.

Optional Feature:
BREAKPOINT_EN:
- Defined:
  - In RUN or STEP at phase 0, with bp_valid=1, pc_addr==bp_addr and resume-skip=0: the next state is IDLE, phase stays 0, the instruction is not executed, instr_cnt is unchanged, and bp_hit is set.
  - resume-skip clears at the first phase-0 cycle after entry, so resuming from a breakpoint executes that instruction.
- Undefined: bp_addr/bp_valid are ignored and bp_hit is tied 0; the ports remain present.

Test Plan:
- Reset then cmd_run, program with no HLT -> phase cycles 0..7 continuously, cpu_en=1, instr_cnt=3 after 24 clks.
- From IDLE, cmd_step -> exactly 8 cpu_en cycles, then IDLE with phase=0 and instr_cnt incremented by 1. cmd_stop+cmd_run in the same cycle while IDLE -> stays IDLE.
- RUN, cmd_stop pulsed at phase 2 -> continues through phase 7, IDLE after that edge. rst asserted at phase 5 -> immediately IDLE, phase=0, instr_cnt=0.
- HLT decoded (halt=1 at phase 4) -> halted=1, phase=0 next cycle. cmd_run -> RUN from phase 0. halt=1 at phase 6 -> ignored.
- HALTED, dbg_req=1 -> dbg_gnt=1 next cycle. dbg_req dropped -> HALTED. dbg_req=1 during RUN -> dbg_gnt stays 0 until stop at instruction boundary, then granted.
- BREAKPOINT_EN, bp_addr=5'h04, bp_valid=1, RUN from PC 0 -> stops with pc_addr=4, bp_hit=1, instr_cnt=4. cmd_run -> bp_hit=0, executes instruction 4 and continues.
